timer_port_arb: RTL and testbench

//  Two-master arbiter for the timer's register port (addr/we/din/dout).

---
 rtl/timer_port_arb.sv | 156 +++++++++++++++
 tb/tb_timer_port_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_port_arb.sv
// Two-master round-robin arbiter for the timer register port.
// Supports bus lock with forced release after LOCK_MAX locked cycles.
module timer_port_arb #(
    parameter int LOCK_MAX = 16,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [1:0]    m0_addr,
    input  logic [DW-1:0] m0_din,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [1:0]    m1_addr,
    input  logic [DW-1:0] m1_din,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    t_addr,
    output logic          t_we,
    output logic [DW-1:0] t_din,
    input  logic [DW-1:0] t_dout
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          cmd_we_q, cmd_we_d;
    logic [1:0]    cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_din_q, cmd_din_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;

    logic          issue;
    logic          req_g;
    logic          lock_g;
    logic          at_max;
    logic          latch;
    logic          src;
    logic [CW-1:0] cnt_nxt;
    logic [DW-1:0] rd_val;

    assign issue   = (state_q == ISSUE);
    assign req_g   = gnt_q ? m1_req : m0_req;
    assign lock_g  = gnt_q ? m1_lock : m0_lock;
    assign cnt_nxt = lock_cnt_q + 1'b1;
    assign at_max  = (cnt_nxt >= CW'(LOCK_MAX));
    // The reserved address reads as zero
    assign rd_val  = (cmd_addr_q == 2'b11) ? '0 : t_dout;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_din_d  = cmd_din_q;
        lock_cnt_d = lock_cnt_q;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        latch      = 1'b0;
        src        = gnt_q;
        unique case (state_q)
            IDLE: begin
                lock_cnt_d = '0;
                if (m0_req || m1_req) begin
                    src     = (m0_req && m1_req) ? ~last_q : m1_req;
                    latch   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_d = gnt_q;
                if (gnt_q) rd1_d = rd_val;
                else       rd0_d = rd_val;
                if (lock_g && !at_max) begin
                    state_d    = HOLD;
                    lock_cnt_d = cnt_nxt;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            HOLD: begin
                // Forced release hands priority to the other master
                if (at_max) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                    last_d     = gnt_q;
                end else if (req_g) begin
                    latch      = 1'b1;
                    state_d    = ISSUE;
                    lock_cnt_d = cnt_nxt;
                end else if (!lock_g) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = cnt_nxt;
                end
            end
            default: state_d = IDLE;
        endcase
        if (latch) begin
            gnt_d      = src;
            cmd_we_d   = src ? m1_we : m0_we;
            cmd_addr_d = src ? m1_addr : m0_addr;
            cmd_din_d  = src ? m1_din : m0_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_din_q  <= '0;
            lock_cnt_q <= '0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_din_q  <= cmd_din_d;
            lock_cnt_q <= lock_cnt_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign m0_ack   = issue && !gnt_q;
    assign m1_ack   = issue && gnt_q;
    assign t_we     = issue && cmd_we_q && (cmd_addr_q != 2'b11);
    assign t_addr   = cmd_addr_q;
    assign t_din    = cmd_din_q;
    assign m0_rdata = m0_ack ? rd_val : rd0_q;
    assign m1_rdata = m1_ack ? rd_val : rd1_q;

endmodule

// File: tb/tb_timer_port_arb.sv
// Bench for timer_port_arb: directed table, lock sequences, reset, random traffic.
module tb_timer_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m0_ack;
    logic [1:0]  m0_addr;
    logic [31:0] m0_din, m0_rdata;
    logic        m1_req, m1_we, m1_lock, m1_ack;
    logic [1:0]  m1_addr;
    logic [31:0] m1_din, m1_rdata;
    logic [1:0]  t_addr;
    logic        t_we;
    logic [31:0] t_din, t_dout;

    logic        mem_init;
    logic [31:0] tmem [4];

    int checks = 0;
    int errors = 0;

    timer_port_arb #(.LOCK_MAX(16), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .t_addr(t_addr), .t_we(t_we), .t_din(t_din), .t_dout(t_dout)
    );

    always #5 clk = ~clk;

    // Timer register file model
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4; i++) tmem[i] <= 32'h1000 + 32'(i);
        end else if (t_we) begin
            tmem[t_addr] <= t_din;
        end
    end
    assign t_dout = tmem[t_addr];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rq0, we0, lk0;
        logic [1:0]  a0;
        logic [31:0] d0;
        logic        rq1, we1, lk1;
        logic [1:0]  a1;
        logic [31:0] d1;
        logic        ea0, ea1, ewe;
        logic [1:0]  eaddr;
        logic [31:0] edin, erd0, erd1;
    } vec_t;

    function automatic vec_t mk(
        input logic rq0, we0, lk0, input logic [1:0] a0, input logic [31:0] d0,
        input logic rq1, we1, lk1, input logic [1:0] a1, input logic [31:0] d1,
        input logic ea0, ea1, ewe, input logic [1:0] eaddr,
        input logic [31:0] edin, erd0, erd1);
        vec_t v;
        v.rq0 = rq0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
        v.rq1 = rq1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
        v.ea0 = ea0; v.ea1 = ea1; v.ewe = ewe; v.eaddr = eaddr;
        v.edin = edin; v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_din = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_din = 0;
    endtask

    vec_t tbl [16];

    // Random-phase reference state
    bit          busy [2];
    logic        q_we [2];
    logic [1:0]  q_addr [2];
    logic [31:0] q_din [2];
    logic [31:0] e_mem [4];
    logic [31:0] e_rd [2];
    bit          e_issue, e_who, e_last, e_we;
    logic [1:0]  e_addr, e_taddr;
    logic [31:0] e_din, e_tdin;

    initial begin
        int n1, c, got;
        idle_inputs();
        mem_init = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack0", 32'(m0_ack), 0);
        chk("rst_ack1", 32'(m1_ack), 0);
        chk("rst_twe", 32'(t_we), 0);
        chk("rst_taddr", 32'(t_addr), 0);
        chk("rst_tdin", t_din, 0);
        chk("rst_rd0", m0_rdata, 0);
        chk("rst_rd1", m1_rdata, 0);
        mem_init = 1'b0;
        rst = 1'b1;

        tbl[0]  = mk(1,0,0,0,0,        1,0,0,2,0, 1,0,0,0,0,        32'h1000,32'h0);
        tbl[1]  = mk(0,0,0,0,0,        1,0,0,2,0, 0,0,0,0,0,        32'h1000,32'h0);
        tbl[2]  = mk(0,0,0,0,0,        1,0,0,2,0, 0,1,0,2,0,        32'h1000,32'h1002);
        tbl[3]  = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,2,0,        32'h1000,32'h1002);
        tbl[4]  = mk(1,0,0,1,0,        1,0,0,0,0, 1,0,0,1,0,        32'h1001,32'h1002);
        tbl[5]  = mk(0,0,0,0,0,        1,0,0,0,0, 0,0,0,1,0,        32'h1001,32'h1002);
        tbl[6]  = mk(0,0,0,0,0,        1,0,0,0,0, 0,1,0,0,0,        32'h1001,32'h1000);
        tbl[7]  = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,0,0,        32'h1001,32'h1000);
        tbl[8]  = mk(1,1,0,1,32'd15,   0,0,0,0,0, 1,0,1,1,32'd15,   32'h1001,32'h1000);
        tbl[9]  = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,1,32'd15,   32'h1001,32'h1000);
        tbl[10] = mk(1,1,0,3,32'hDEAD, 0,0,0,0,0, 1,0,0,3,32'hDEAD, 32'h0,32'h1000);
        tbl[11] = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,3,32'hDEAD, 32'h0,32'h1000);
        tbl[12] = mk(1,0,0,3,0,        0,0,0,0,0, 1,0,0,3,0,        32'h0,32'h1000);
        tbl[13] = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,3,0,        32'h0,32'h1000);
        tbl[14] = mk(1,0,0,1,0,        0,0,0,0,0, 1,0,0,1,0,        32'd15,32'h1000);
        tbl[15] = mk(0,0,0,0,0,        0,0,0,0,0, 0,0,0,1,0,        32'd15,32'h1000);

        foreach (tbl[i]) begin
            m0_req = tbl[i].rq0; m0_we = tbl[i].we0; m0_lock = tbl[i].lk0;
            m0_addr = tbl[i].a0; m0_din = tbl[i].d0;
            m1_req = tbl[i].rq1; m1_we = tbl[i].we1; m1_lock = tbl[i].lk1;
            m1_addr = tbl[i].a1; m1_din = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("v%0d_ack0", i), 32'(m0_ack), 32'(tbl[i].ea0));
            chk($sformatf("v%0d_ack1", i), 32'(m1_ack), 32'(tbl[i].ea1));
            chk($sformatf("v%0d_twe", i), 32'(t_we), 32'(tbl[i].ewe));
            chk($sformatf("v%0d_taddr", i), 32'(t_addr), 32'(tbl[i].eaddr));
            chk($sformatf("v%0d_tdin", i), t_din, tbl[i].edin);
            chk($sformatf("v%0d_rd0", i), m0_rdata, tbl[i].erd0);
            chk($sformatf("v%0d_rd1", i), m1_rdata, tbl[i].erd1);
        end

        // m1 locked burst of three reads while m0 waits
        m0_req = 1; m0_addr = 0;
        m1_req = 1; m1_lock = 1; m1_addr = 2'b10;
        n1 = 0; got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            chk("lk_both", 32'(m0_ack && m1_ack), 0);
            if (m1_ack) begin
                n1++;
                chk("lk_rd1", m1_rdata, 32'h1002);
                if (n1 == 3) begin m1_req = 0; m1_lock = 0; end
            end
            if (m0_ack) begin
                got = 1;
                chk("lk_order", 32'(n1), 3);
                m0_req = 0;
            end
        end
        chk("lk_m0_served", 32'(got), 1);
        idle_inputs();
        @(negedge clk);

        // m1 sits on the lock; m0 must get in after forced release
        m1_req = 1; m1_lock = 1; m1_addr = 2'b10;
        got = 0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (m1_ack) got = 1;
        end
        chk("fr_m1_ack", 32'(got), 1);
        m1_req = 0;
        m0_req = 1; m0_addr = 0;
        c = 0; got = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (m1_ack) chk("fr_stray_m1", 32'(m1_ack), 0);
            if (m0_ack) begin got = 1; c = k; end
        end
        chk("fr_m0_served", 32'(got), 1);
        chk("fr_latency", 32'(c), 17);
        idle_inputs();
        repeat (2) @(negedge clk);

        // Reset asserted during ISSUE of a write
        m0_req = 1; m0_we = 1; m0_addr = 0; m0_din = 32'h55;
        @(negedge clk);
        chk("rs_twe_pre", 32'(t_we), 1);
        chk("rs_ack_pre", 32'(m0_ack), 1);
        #1 rst = 1'b0;
        #1;
        chk("rs_twe", 32'(t_we), 0);
        chk("rs_ack", 32'(m0_ack), 0);
        chk("rs_taddr", 32'(t_addr), 0);
        idle_inputs();
        mem_init = 1'b1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rs_no_ack", 32'(m0_ack | m1_ack), 0);
        end

        // Random traffic against a transaction-level reference
        for (int i = 0; i < 4; i++) e_mem[i] = 32'h1000 + 32'(i);
        e_rd[0] = 0; e_rd[1] = 0;
        busy[0] = 0; busy[1] = 0;
        e_issue = 0; e_last = 1; e_who = 0;
        e_taddr = 0; e_tdin = 0; e_we = 0; e_addr = 0; e_din = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (e_issue) begin
                e_taddr = e_addr;
                e_tdin = e_din;
                e_rd[e_who] = (e_addr == 2'b11) ? 32'h0 : e_mem[e_addr];
            end
            chk("r_ack0", 32'(m0_ack), 32'(e_issue && !e_who));
            chk("r_ack1", 32'(m1_ack), 32'(e_issue && e_who));
            chk("r_twe", 32'(t_we), 32'(e_issue && e_we && e_addr != 2'b11));
            chk("r_taddr", 32'(t_addr), 32'(e_taddr));
            chk("r_tdin", t_din, e_tdin);
            chk("r_rd0", m0_rdata, e_rd[0]);
            chk("r_rd1", m1_rdata, e_rd[1]);
            if (e_issue) begin
                if (e_we && e_addr != 2'b11) e_mem[e_addr] = e_din;
                busy[e_who] = 0;
                e_last = e_who;
            end
            for (int m = 0; m < 2; m++) begin
                if (!busy[m] && $urandom_range(0, 1) == 1) begin
                    busy[m] = 1;
                    q_we[m] = 1'($urandom_range(0, 1));
                    q_addr[m] = 2'($urandom_range(0, 3));
                    q_din[m] = $urandom;
                end
            end
            m0_req = busy[0]; m0_we = q_we[0]; m0_addr = q_addr[0]; m0_din = q_din[0];
            m1_req = busy[1]; m1_we = q_we[1]; m1_addr = q_addr[1]; m1_din = q_din[1];
            if (e_issue) begin
                e_issue = 0;
            end else if (busy[0] || busy[1]) begin
                e_who = (busy[0] && busy[1]) ? !e_last : busy[1];
                e_we = q_we[e_who];
                e_addr = q_addr[e_who];
                e_din = q_din[e_who];
                e_issue = 1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
